input_layer_buffer: RTL
=======================

# input_layer_buffer

Input-side buffering stage of the ConvNet accelerator. It accepts the pixel stream (Nin channels per pixel) from the external source over the `input_layer_valid`/`input_layer_rdy` handshake and holds it in a small FIFO. It presents pixels to the first convolution stage over a second valid/ready handshake, tagging each pixel with its row/column position and an end-of-frame flag. It decouples source stalls from array stalls and supplies the spatial bookkeeping the downstream stage needs.

## Interface
- `Nin`, 3, input feature maps (channels) per pixel
- `BIT_WIDTH`, 8, bits per channel sample
- `IMG_WIDTH`, 5, pixels per row
- `IMG_HEIGHT`, 5, rows per frame
- `FIFO_DEPTH`, 4, buffer entries; power of two, ≥2
- `clk` input 1 system clock; all state on rising edge
- `rst` input 1 system reset; asynchronous, active-high
- `input_layer_valid` input 1 source data valid
- `input_layer_data` input Nin*BIT_WIDTH pixel; channel i at [i*BIT_WIDTH +: BIT_WIDTH]
- `input_layer_rdy` output 1 buffer can accept a pixel (registered)
- `out_valid` output 1 head pixel valid
- `out_data` output Nin*BIT_WIDTH head pixel, same packing as input
- `out_row` output clog2(IMG_HEIGHT) row of head pixel
- `out_col` output clog2(IMG_WIDTH) column of head pixel
- `out_last` output 1 head pixel is last of frame (row H-1, col W-1)
- `out_rdy` input 1 downstream accepts head pixel
- `frame_done` output 1 one-cycle pulse after last pixel of a frame is popped
- clog2 widths are at least 1 bit.

## Operation
- Push: `input_layer_valid && input_layer_rdy` at a rising edge writes `input_layer_data` to `mem[wr_ptr]`; wr_ptr increments modulo FIFO_DEPTH.
- Pop: `out_valid && out_rdy` at a rising edge; rd_ptr increments modulo FIFO_DEPTH.
- `count` (0..FIFO_DEPTH): +1 on push only, −1 on pop only, unchanged on both/neither.
- `out_valid = (count != 0)`; `out_data = mem[rd_ptr]` (read from registered state, no path from `input_layer_data`).
- `input_layer_rdy` is a register: next value = (next_count != FIFO_DEPTH). No combinational path from `input_layer_valid` or `out_rdy`.
- Position counters advance on pop only. col+1. At col = IMG_WIDTH-1, col→0 and row+1. At row = IMG_HEIGHT-1 and col = IMG_WIDTH-1, both →0 (frame wrap).
- `out_row`/`out_col` always show the position the head pixel will occupy. They are valid whenever `out_valid` = 1 and hold their values while `out_valid` = 0.
- `out_last` = (row == IMG_HEIGHT-1) && (col == IMG_WIDTH-1); combinational from the counters.
- `frame_done` registered: 1 for exactly one cycle following the edge that popped an `out_last` pixel.
- Data content is not inspected; any value including 0 passes unchanged.

## Timing
- Reset (async assert): count=0, wr_ptr=rd_ptr=0, row=col=0, `input_layer_rdy`=0, `out_valid`=0, `out_last`=0 (IMG 1×1: 1), `frame_done`=0. Memory contents are don't-care.
- First edge after reset release: `input_layer_rdy` → 1.
- Latency: a pixel pushed at edge k is on `out_data` with `out_valid`=1 from edge k to edge k+1 when the FIFO was empty (1 cycle).
- Throughput: 1 pixel/cycle sustained when `out_rdy`=1 continuously.
- Full: at count = FIFO_DEPTH, `input_layer_rdy`=0; a valid held by the source is not consumed. A pop at that edge makes `input_layer_rdy`=1 the next cycle (1-cycle bubble at full).
- Empty: `out_valid`=0; `out_rdy` is ignored and counters don't move.
- Simultaneous push+pop (0<count<FIFO_DEPTH): count unchanged; both pointers advance.
- `out_rdy` deasserted: head pixel, `out_row`, `out_col`, `out_last` held stable.
- Reset mid-frame or mid-burst: buffered pixels discarded; the next pixel accepted is row 0, col 0; `frame_done` is not emitted for the aborted frame.

## Test plan
- Reset, then source streams 1,2,3… with `out_rdy`=1 → `input_layer_rdy`=1 from first edge after reset; out_data sequence 1,2,3… one per cycle after 1-cycle latency; all Nin lanes equal.
- 5×5 frame, `out_rdy`=1 → `out_last`=1 only on 25th pixel (row 4, col 4); `frame_done` pulses the cycle after; pixel 26 shows row 0, col 0.
- `out_rdy`=0, source always valid → exactly 4 pixels accepted, then `input_layer_rdy`=0. Raise `out_rdy` → pixels 1..4 in order, `input_layer_rdy` back to 1 one cycle after the first pop, no loss or duplication.
- Random `input_layer_valid`/`out_rdy` (50% each) over 3 frames → output equals input order; row/col/`out_last`/`frame_done` match a reference counter model; count never exceeds 4.
- Assert `rst` after 7 pixels popped with 2 buffered → all outputs at reset values immediately. The next accepted pixel appears at row 0, col 0, and the 2 stale pixels never appear.
- `out_rdy`=0 with `out_valid`=1 for 3 cycles → `out_data`, `out_row`, `out_col`, and `out_last` stable across all 3 cycles.

Source files
------------

// File: rtl/input_layer_buffer.sv
// Input-side pixel FIFO for the ConvNet accelerator: buffers the source stream and
// tags each pixel leaving the buffer with its row/column and an end-of-frame flag.
module input_layer_buffer #(
    parameter int Nin        = 3,
    parameter int BIT_WIDTH  = 8,
    parameter int IMG_WIDTH  = 5,
    parameter int IMG_HEIGHT = 5,
    parameter int FIFO_DEPTH = 4,
    localparam int DATA_W = Nin * BIT_WIDTH,
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_layer_valid,
    input  logic [DATA_W-1:0] input_layer_data,
    output logic              input_layer_rdy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_last,
    input  logic              out_rdy,
    output logic              frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX    = COL_W'(IMG_WIDTH - 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             rdy_q, rdy_d;
    logic             frame_done_q, frame_done_d;

    logic push;
    logic pop;

    assign out_valid       = (count_q != '0);
    assign out_data        = mem_q[rd_ptr_q];
    assign out_row         = row_q;
    assign out_col         = col_q;
    assign out_last        = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign input_layer_rdy = rdy_q;
    assign frame_done      = frame_done_q;

    always_comb begin
        push         = input_layer_valid && rdy_q;
        pop          = out_valid && out_rdy;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = pop && out_last;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Ready is registered, so it is derived from the post-edge occupancy.
        rdy_d = (count_d != COUNT_FULL);

        // Position tracks the next pixel to leave; it moves only on a pop.
        if (pop) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            rdy_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            row_q        <= row_d;
            col_q        <= col_d;
            rdy_q        <= rdy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= input_layer_data;
        end
    end

endmodule
